// File: rtl/servo_ramp_controller.sv
// Servo ramp controller: a CPU custom-instruction slave that holds two target
// duty values and walks the live duty of each channel toward its target in
// fixed steps at a programmable tick rate, pushing every change to a PWM
// generator through a second custom-instruction port.
module servo_ramp_controller #(
    parameter logic [7:0] customId    = 8'h00,
    parameter logic [7:0] pwmCustomId = 8'h01
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  ciN,
    output logic        done,
    output logic [31:0] result,
    output logic        pwm_start,
    output logic [31:0] pwm_valueA,
    output logic [31:0] pwm_valueB,
    output logic [7:0]  pwm_ciN,
    input  logic        pwm_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRMASK,
        ST_COUNT,
        ST_CALC,
        ST_WR0,
        ST_WR1
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] cur0_q, cur0_d;
    logic [19:0] cur1_q, cur1_d;
    logic [19:0] tgt0_q, tgt0_d;
    logic [19:0] tgt1_q, tgt1_d;
    logic [19:0] step_q, step_d;
    logic [23:0] period_q, period_d;
    logic [23:0] cnt_q, cnt_d;
    logic [1:0]  mask_q, mask_d;
    logic        mask_dirty_q, mask_dirty_d;
    logic        ch1_chg_q, ch1_chg_d;
    logic        pwm_start_q, pwm_start_d;
    logic [31:0] pwm_valueA_q, pwm_valueA_d;
    logic [31:0] pwm_valueB_q, pwm_valueB_d;

    logic [2:0]  opcode;
    logic        cpu_wr;
    logic [19:0] nxt0, nxt1;
    logic [19:0] cur_sel;
    logic        unused_bits;

    // One ramp step toward the target, clamped so the target is never passed;
    // a zero step jumps straight to the target.
    function automatic logic [19:0] ramp_next(input logic [19:0] cur,
                                              input logic [19:0] tgt,
                                              input logic [19:0] step);
        logic [20:0] sum;
        logic [20:0] gap;
        sum       = {1'b0, cur} + {1'b0, step};
        gap       = {1'b0, cur} - {1'b0, tgt};
        ramp_next = tgt;
        if (step != 20'd0) begin
            if (cur < tgt) begin
                if (sum < {1'b0, tgt}) ramp_next = sum[19:0];
            end else if (cur > tgt) begin
                if ({1'b0, step} < gap) ramp_next = cur - step;
            end
        end
        return ramp_next;
    endfunction

    assign opcode      = valueA[2:0];
    assign done        = start && (ciN == customId);
    assign cpu_wr      = done && reset_n;
    assign nxt0        = ramp_next(cur0_q, tgt0_q, step_q);
    assign nxt1        = ramp_next(cur1_q, tgt1_q, step_q);
    assign cur_sel     = valueA[3] ? cur1_q : cur0_q;
    assign unused_bits = &{1'b0, valueA[31:4], valueB[31:24]};

    assign pwm_start  = pwm_start_q;
    assign pwm_valueA = pwm_valueA_q;
    assign pwm_valueB = pwm_valueB_q;
    assign pwm_ciN    = pwmCustomId;

    // Status read data is only driven while this block is answering an instruction.
    always_comb begin
        result = 32'd0;
        if (done && (opcode == 3'd5)) begin
            result = {(state_q != ST_IDLE), 11'd0, cur_sel};
        end
    end

    // Next-state logic: CPU register writes and the ramp/PWM-write sequencer.
    always_comb begin
        state_d      = state_q;
        cur0_d       = cur0_q;
        cur1_d       = cur1_q;
        tgt0_d       = tgt0_q;
        tgt1_d       = tgt1_q;
        step_d       = step_q;
        period_d     = period_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        mask_dirty_d = mask_dirty_q;
        ch1_chg_d    = ch1_chg_q;
        pwm_start_d  = pwm_start_q;
        pwm_valueA_d = pwm_valueA_q;
        pwm_valueB_d = pwm_valueB_q;

        if (cpu_wr) begin
            case (opcode)
                3'd0:    mask_d   = valueB[1:0];
                3'd1:    tgt0_d   = valueB[19:0];
                3'd2:    tgt1_d   = valueB[19:0];
                3'd3:    step_d   = valueB[19:0];
                3'd4:    period_d = valueB[23:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (mask_dirty_q) begin
                    state_d      = ST_WRMASK;
                    pwm_start_d  = 1'b1;
                    pwm_valueA_d = {28'd0, 2'b00, mask_q};
                    pwm_valueB_d = 32'd0;
                end else if ((cur0_q != tgt0_q) || (cur1_q != tgt1_q)) begin
                    state_d = ST_COUNT;
                    cnt_d   = period_q;
                end
            end
            ST_WRMASK: begin
                if (pwm_done) begin
                    state_d      = ST_IDLE;
                    pwm_start_d  = 1'b0;
                    mask_dirty_d = 1'b0;
                end
            end
            ST_COUNT: begin
                if (cnt_q == 24'd0) begin
                    state_d = ST_CALC;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            ST_CALC: begin
                cur0_d    = nxt0;
                cur1_d    = nxt1;
                ch1_chg_d = (nxt1 != cur1_q);
                if (nxt0 != cur0_q) begin
                    state_d      = ST_WR0;
                    pwm_start_d  = 1'b1;
                    pwm_valueA_d = {28'd0, 2'b01, mask_q};
                    pwm_valueB_d = {12'd0, nxt0};
                end else if (nxt1 != cur1_q) begin
                    state_d      = ST_WR1;
                    pwm_start_d  = 1'b1;
                    pwm_valueA_d = {28'd0, 2'b10, mask_q};
                    pwm_valueB_d = {12'd0, nxt1};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR0: begin
                if (pwm_done) begin
                    if (ch1_chg_q) begin
                        state_d      = ST_WR1;
                        pwm_valueA_d = {28'd0, 2'b10, mask_q};
                        pwm_valueB_d = {12'd0, cur1_q};
                    end else begin
                        state_d     = ST_IDLE;
                        pwm_start_d = 1'b0;
                    end
                end
            end
            ST_WR1: begin
                if (pwm_done) begin
                    state_d     = ST_IDLE;
                    pwm_start_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                pwm_start_d = 1'b0;
            end
        endcase

        if (cpu_wr && (opcode == 3'd0)) begin
            mask_dirty_d = 1'b1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cur0_q       <= 20'd0;
            cur1_q       <= 20'd0;
            tgt0_q       <= 20'd0;
            tgt1_q       <= 20'd0;
            step_q       <= 20'd0;
            period_q     <= 24'd0;
            cnt_q        <= 24'd0;
            mask_q       <= 2'd0;
            mask_dirty_q <= 1'b0;
            ch1_chg_q    <= 1'b0;
            pwm_start_q  <= 1'b0;
            pwm_valueA_q <= 32'd0;
            pwm_valueB_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cur0_q       <= cur0_d;
            cur1_q       <= cur1_d;
            tgt0_q       <= tgt0_d;
            tgt1_q       <= tgt1_d;
            step_q       <= step_d;
            period_q     <= period_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            mask_dirty_q <= mask_dirty_d;
            ch1_chg_q    <= ch1_chg_d;
            pwm_start_q  <= pwm_start_d;
            pwm_valueA_q <= pwm_valueA_d;
            pwm_valueB_q <= pwm_valueB_d;
        end
    end

endmodule

// File: tb/tb_servo_ramp_controller.sv
// Directed testbench for servo_ramp_controller: a CPU-side driver, a PWM
// generator responder with programmable acknowledge delay, and one task per
// scenario with hand-computed expectations.
module tb_servo_ramp_controller;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [7:0]  ciN;
    logic        done;
    logic [31:0] result;
    logic        pwm_start;
    logic [31:0] pwm_valueA;
    logic [31:0] pwm_valueB;
    logic [7:0]  pwm_ciN;
    logic        pwm_done;

    int checks = 0;
    int errors = 0;

    servo_ramp_controller #(
        .customId   (8'h00),
        .pwmCustomId(8'h01)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .valueA    (valueA),
        .valueB    (valueB),
        .ciN       (ciN),
        .done      (done),
        .result    (result),
        .pwm_start (pwm_start),
        .pwm_valueA(pwm_valueA),
        .pwm_valueB(pwm_valueB),
        .pwm_ciN   (pwm_ciN),
        .pwm_done  (pwm_done)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        start    = 1'b0;
        valueA   = 32'd0;
        valueB   = 32'd0;
        ciN      = 8'h00;
        pwm_done = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic cpu_write(input logic [2:0] op, input logic [31:0] data);
        start  = 1'b1;
        ciN    = 8'h00;
        valueA = {29'd0, op};
        valueB = data;
        tick();
        start  = 1'b0;
        valueA = 32'd0;
        valueB = 32'd0;
    endtask

    task automatic status_read(input logic ch, output logic [31:0] res, output logic dn);
        start  = 1'b1;
        ciN    = 8'h00;
        valueA = {28'd0, ch, 3'd5};
        #1;
        res    = result;
        dn     = done;
        start  = 1'b0;
        valueA = 32'd0;
    endtask

    // Waits for a PWM write, captures it, then acknowledges after 'hold' cycles.
    task automatic wait_write(input int hold, input int limit,
                              output logic [31:0] a, output logic [31:0] b,
                              output int waited, output bit ok);
        ok = 1'b0; waited = 0; a = 32'd0; b = 32'd0;
        while ((pwm_start !== 1'b1) && (waited < limit)) begin
            tick();
            waited++;
        end
        if (pwm_start === 1'b1) begin
            ok = 1'b1;
            a  = pwm_valueA;
            b  = pwm_valueB;
            repeat (hold) tick();
            pwm_done = 1'b1;
            tick();
            pwm_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] r; logic d;
        do_reset();
        checks++;
        if (pwm_start !== 1'b0 || pwm_valueA !== 32'd0 || pwm_valueB !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: start=%b A=%h B=%h, required 0/0/0", pwm_start, pwm_valueA, pwm_valueB);
        end
        checks++;
        if (pwm_ciN !== 8'h01) begin
            errors++;
            $display("[TB] FAIL pwm_ciN: got %h, required 01", pwm_ciN);
        end
        status_read(1'b0, r, d);
        checks++;
        if (d !== 1'b1 || r !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_status: done=%b result=%h, required 1/00000000", d, r);
        end
        // Wrong instruction number: no done, no result.
        start = 1'b1; ciN = 8'h05; valueA = 32'd5;
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("[TB] FAIL foreign_ciN: done=%b result=%h, required 0/00000000", done, result);
        end
        // No-op opcode answers with zero.
        ciN = 8'h00; valueA = 32'd6;
        #1;
        checks++;
        if (done !== 1'b1 || result !== 32'd0) begin
            errors++;
            $display("[TB] FAIL noop_op: done=%b result=%h, required 1/00000000", done, result);
        end
        start = 1'b0; valueA = 32'd0;
    endtask

    task automatic test_mask_write();
        logic [31:0] a, b; int w; bit ok;
        do_reset();
        cpu_write(3'd0, 32'd3);
        w = 0;
        while (pwm_start !== 1'b1 && w < 20) begin tick(); w++; end
        repeat (2) tick();
        checks++;
        if (pwm_start !== 1'b1 || pwm_valueA !== 32'h3) begin
            errors++;
            $display("[TB] FAIL mask_hold: start=%b A=%h, required 1/00000003", pwm_start, pwm_valueA);
        end
        wait_write(0, 5, a, b, w, ok);
        checks++;
        if (!ok || a !== 32'h3) begin
            errors++;
            $display("[TB] FAIL mask_write: ok=%b A=%h, required 1/00000003", ok, a);
        end
        checks++;
        if (pwm_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mask_drop: start=%b, required 0", pwm_start);
        end
        wait_write(0, 30, a, b, w, ok);
        checks++;
        if (ok) begin
            errors++;
            $display("[TB] FAIL mask_no_duty: unexpected write A=%h B=%h, required none", a, b);
        end
    endtask

    task automatic test_step_zero();
        logic [31:0] a, b; int w; bit ok;
        do_reset();
        cpu_write(3'd0, 32'd1);
        wait_write(0, 20, a, b, w, ok);
        cpu_write(3'd1, 32'd1000);
        wait_write(0, 40, a, b, w, ok);
        checks++;
        if (!ok || a !== 32'h5 || b !== 32'd1000) begin
            errors++;
            $display("[TB] FAIL step0_write: ok=%b A=%h B=%0d, required 1/00000005/1000", ok, a, b);
        end
        wait_write(0, 30, a, b, w, ok);
        checks++;
        if (ok) begin
            errors++;
            $display("[TB] FAIL step0_single: extra write A=%h B=%0d, required none", a, b);
        end
    endtask

    task automatic test_ramp_up();
        logic [31:0] a, b, r; logic d; int w; bit ok;
        logic [31:0] exp_duty [4];
        exp_duty = '{32'd300, 32'd600, 32'd900, 32'd1000};
        do_reset();
        cpu_write(3'd3, 32'd300);
        cpu_write(3'd4, 32'd9);
        cpu_write(3'd1, 32'd1000);
        for (int i = 0; i < 4; i++) begin
            wait_write(0, 100, a, b, w, ok);
            checks++;
            if (!ok || a !== 32'h4 || b !== exp_duty[i] || w !== 12) begin
                errors++;
                $display("[TB] FAIL ramp_up_%0d: ok=%b A=%h B=%0d wait=%0d, required 1/00000004/%0d/12",
                         i, ok, a, b, w, exp_duty[i]);
            end
        end
        status_read(1'b0, r, d);
        checks++;
        if (r !== 32'd1000) begin
            errors++;
            $display("[TB] FAIL ramp_up_idle: result=%h, required 000003e8", r);
        end
    endtask

    task automatic test_ramp_down();
        logic [31:0] a, b; int w; bit ok;
        logic [31:0] exp_duty [3];
        exp_duty = '{32'd600, 32'd200, 32'd150};
        do_reset();
        cpu_write(3'd2, 32'd1000);
        wait_write(0, 40, a, b, w, ok);
        checks++;
        if (!ok || a !== 32'h8 || b !== 32'd1000) begin
            errors++;
            $display("[TB] FAIL ch1_preset: ok=%b A=%h B=%0d, required 1/00000008/1000", ok, a, b);
        end
        cpu_write(3'd3, 32'd400);
        cpu_write(3'd2, 32'd150);
        for (int i = 0; i < 3; i++) begin
            wait_write(0, 40, a, b, w, ok);
            checks++;
            if (!ok || a !== 32'h8 || b !== exp_duty[i]) begin
                errors++;
                $display("[TB] FAIL ramp_down_%0d: ok=%b A=%h B=%0d, required 1/00000008/%0d",
                         i, ok, a, b, exp_duty[i]);
            end
        end
        wait_write(0, 30, a, b, w, ok);
        checks++;
        if (ok) begin
            errors++;
            $display("[TB] FAIL ramp_down_end: extra write A=%h B=%0d, required none", a, b);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a0, b0, r; logic d; int w;
        do_reset();
        cpu_write(3'd1, 32'd500);
        w = 0;
        while (pwm_start !== 1'b1 && w < 40) begin tick(); w++; end
        a0 = pwm_valueA;
        b0 = pwm_valueB;
        checks++;
        if (pwm_start !== 1'b1 || a0 !== 32'h4 || b0 !== 32'd500) begin
            errors++;
            $display("[TB] FAIL stall_entry: start=%b A=%h B=%0d, required 1/00000004/500", pwm_start, a0, b0);
        end
        status_read(1'b0, r, d);
        checks++;
        if (r !== 32'h800001F4) begin
            errors++;
            $display("[TB] FAIL stall_busy: result=%h, required 800001f4", r);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) pwm_done = 1'b1;
            checks++;
            if (pwm_start !== 1'b1 || pwm_valueA !== a0 || pwm_valueB !== b0) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: start=%b A=%h B=%h, required 1/%h/%h",
                         i, pwm_start, pwm_valueA, pwm_valueB, a0, b0);
            end
        end
        tick();
        pwm_done = 1'b0;
        checks++;
        if (pwm_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_drop: start=%b, required 0", pwm_start);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] a, b, r; logic d; int w; bit ok;
        do_reset();
        cpu_write(3'd2, 32'd700);
        w = 0;
        while (pwm_start !== 1'b1 && w < 40) begin tick(); w++; end
        checks++;
        if (pwm_start !== 1'b1 || pwm_valueA !== 32'h8) begin
            errors++;
            $display("[TB] FAIL wr1_entry: start=%b A=%h, required 1/00000008", pwm_start, pwm_valueA);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if (pwm_start !== 1'b0 || pwm_valueA !== 32'd0 || pwm_valueB !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid: start=%b A=%h B=%h, required 0/0/0", pwm_start, pwm_valueA, pwm_valueB);
        end
        status_read(1'b1, r, d);
        checks++;
        if (d !== 1'b1 || r !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_status: done=%b result=%h, required 1/00000000", d, r);
        end
        cpu_write(3'd1, 32'd77);
        reset_n = 1'b1;
        wait_write(0, 30, a, b, w, ok);
        checks++;
        if (ok) begin
            errors++;
            $display("[TB] FAIL reset_write_ignored: write A=%h B=%0d, required none", a, b);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        valueA   = 32'd0;
        valueB   = 32'd0;
        ciN      = 8'h00;
        pwm_done = 1'b0;
        test_reset();
        test_mask_write();
        test_step_zero();
        test_ramp_up();
        test_ramp_down();
        test_stall();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
